// File: rtl/chimera_clu_pwr_seq.sv
// ---------------------------------------------------------------------------
// chimera_clu_pwr_seq
//
// Purpose:
//    Power sequencer for the external compute clusters. One shared FSM walks
//    a single cluster at a time through its power-up sequence (clock on,
//    reset release, de-isolate) or its power-down sequence (isolate, drain
//    outstanding AXI traffic, reset assert, clock off). Pending requests are
//    arbitrated round-robin so that no cluster can starve the others.
//
// Ports:
//    soc_clk_i      - single clock, all state changes on its rising edge
//    rst_i          - synchronous active-high reset
//    req_valid_i    - per-cluster power-change request, held until granted
//    req_on_i       - per-cluster requested target (1 = up, 0 = down)
//    req_ready_o    - one-hot, one-cycle grant pulse (only while idle)
//    busy_i         - per-cluster "AXI transactions outstanding" flag
//    clu_clk_en_o   - per-cluster clock-gate enable
//    clu_rst_no     - per-cluster reset, active low
//    clu_isolate_o  - per-cluster AXI isolation enable
//    clu_active_o   - per-cluster "fully powered up" status
//    done_o         - one-cycle pulse when a sequence completes
//    error_o        - one-cycle pulse alongside done_o on a drain timeout
//    done_idx_o     - cluster index belonging to done_o/error_o
// ---------------------------------------------------------------------------
module chimera_clu_pwr_seq #(
   parameter int NumClusters     = 5,
   parameter int ClkSettleCycles = 4,
   parameter int RstHoldCycles   = 8,
   parameter int DrainTimeout    = 1024
) (
   input  logic                   soc_clk_i,
   input  logic                   rst_i,
   input  logic [NumClusters-1:0] req_valid_i,
   input  logic [NumClusters-1:0] req_on_i,
   output logic [NumClusters-1:0] req_ready_o,
   input  logic [NumClusters-1:0] busy_i,
   output logic [NumClusters-1:0] clu_clk_en_o,
   output logic [NumClusters-1:0] clu_rst_no,
   output logic [NumClusters-1:0] clu_isolate_o,
   output logic [NumClusters-1:0] clu_active_o,
   output logic                   done_o,
   output logic                   error_o,
   output logic [(NumClusters > 1 ? $clog2(NumClusters) : 1)-1:0] done_idx_o
);

   // Index width is kept at least one bit so a single-cluster build still
   // has legal vectors.
   localparam int IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;

   // One counter times every wait, so it is sized for the longest of them.
   localparam int MaxWait0 = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
   localparam int MaxWait  = (DrainTimeout > MaxWait0) ? DrainTimeout : MaxWait0;
   localparam int CntW     = $clog2(MaxWait + 1);

   // The counter is loaded with N-1 on entry and the state exits in the cycle
   // it reads zero, which makes the state last exactly N cycles.
   localparam logic [CntW-1:0] SettleLoad = CntW'(ClkSettleCycles - 1);
   localparam logic [CntW-1:0] HoldLoad   = CntW'(RstHoldCycles - 1);
   localparam logic [CntW-1:0] DrainLoad  = CntW'(DrainTimeout - 1);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumClusters - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLK_ON,
      RST_REL,
      DRAIN,
      RST_ASSERT,
      CLK_OFF,
      FINISH
   } state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [IdxW-1:0]        rr_q, rr_d;
   logic                   err_q, err_d;
   logic [NumClusters-1:0] clk_en_q, clk_en_d;
   logic [NumClusters-1:0] rst_n_q, rst_n_d;
   logic [NumClusters-1:0] iso_q, iso_d;
   logic [NumClusters-1:0] active_q, active_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic [IdxW-1:0]        done_idx_q, done_idx_d;

   logic                   gnt_found;
   logic [IdxW-1:0]        gnt_idx;
   int                     cand;

   // Round-robin search: walk the clusters starting at rr_q and take the
   // first one with a pending request. The candidate index wraps manually so
   // non-power-of-two cluster counts work.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int i = 0; i < NumClusters; i++) begin
         cand = int'(rr_q) + i;
         if (cand >= NumClusters) begin
            cand = cand - NumClusters;
         end
         if (!gnt_found && req_valid_i[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = IdxW'(cand);
         end
      end
   end

   // The grant pulse is combinational in the IDLE cycle itself; it is gated
   // with rst_i so nothing is granted while the block is held in reset.
   always_comb begin
      req_ready_o = '0;
      if (state_q == IDLE && gnt_found && !rst_i) begin
         req_ready_o = NumClusters'(1) << gnt_idx;
      end
   end

   // Next-state and per-cluster output logic. Only the bit of the cluster
   // being sequenced is ever touched, so every other cluster holds its
   // outputs. The up/down decision is taken in IDLE from the granted
   // req_on_i bit and is carried by the state path afterwards, so later
   // changes of req_on_i have no effect.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      rr_d       = rr_q;
      err_d      = err_q;
      clk_en_d   = clk_en_q;
      rst_n_d    = rst_n_q;
      iso_d      = iso_q;
      active_d   = active_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      done_idx_d = '0;

      unique case (state_q)
         IDLE: begin
            if (gnt_found) begin
               idx_d = gnt_idx;
               rr_d  = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
               err_d = 1'b0;
               // Requesting the state the cluster is already in is a no-op
               // that still reports completion.
               if (req_on_i[gnt_idx] == active_q[gnt_idx]) begin
                  state_d = FINISH;
               end else if (req_on_i[gnt_idx]) begin
                  state_d           = CLK_ON;
                  clk_en_d[gnt_idx] = 1'b1;
                  cnt_d             = SettleLoad;
               end else begin
                  state_d        = DRAIN;
                  iso_d[gnt_idx] = 1'b1;
                  cnt_d          = DrainLoad;
               end
            end
         end

         CLK_ON: begin
            if (cnt_q == '0) begin
               state_d        = RST_REL;
               rst_n_d[idx_q] = 1'b1;
               cnt_d          = HoldLoad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         RST_REL: begin
            if (cnt_q == '0) begin
               state_d         = FINISH;
               iso_d[idx_q]    = 1'b0;
               active_d[idx_q] = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         // Busy is checked before the timeout so a cluster that goes quiet
         // in the very last allowed cycle still powers down normally. On a
         // timeout the cluster stays up, so its isolation is lifted again.
         DRAIN: begin
            if (!busy_i[idx_q]) begin
               state_d        = RST_ASSERT;
               rst_n_d[idx_q] = 1'b0;
               cnt_d          = HoldLoad;
            end else if (cnt_q == '0) begin
               state_d      = FINISH;
               iso_d[idx_q] = 1'b0;
               err_d        = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         RST_ASSERT: begin
            if (cnt_q == '0) begin
               state_d         = CLK_OFF;
               clk_en_d[idx_q] = 1'b0;
               active_d[idx_q] = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         CLK_OFF: begin
            state_d = FINISH;
         end

         // Completion is registered, so done_o/error_o/done_idx_o appear in
         // the cycle after FINISH, which is already back in IDLE.
         FINISH: begin
            state_d    = IDLE;
            done_d     = 1'b1;
            error_d    = err_q;
            done_idx_d = idx_q;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset puts every cluster into the safe
   // "off" configuration: clock gated, in reset, isolated, not active. A
   // sequence interrupted by reset is simply dropped without a done pulse.
   always_ff @(posedge soc_clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         rr_q       <= '0;
         err_q      <= 1'b0;
         clk_en_q   <= '0;
         rst_n_q    <= '0;
         iso_q      <= '1;
         active_q   <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         done_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         rr_q       <= rr_d;
         err_q      <= err_d;
         clk_en_q   <= clk_en_d;
         rst_n_q    <= rst_n_d;
         iso_q      <= iso_d;
         active_q   <= active_d;
         done_q     <= done_d;
         error_q    <= error_d;
         done_idx_q <= done_idx_d;
      end
   end

   assign clu_clk_en_o  = clk_en_q;
   assign clu_rst_no    = rst_n_q;
   assign clu_isolate_o = iso_q;
   assign clu_active_o  = active_q;
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign done_idx_o    = done_idx_q;

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// ---------------------------------------------------------------------------
// tb_chimera_clu_pwr_seq
//
// Purpose:
//    Directed bench for the cluster power sequencer. Each task drives one
//    scenario with hand-computed cycle offsets relative to the grant cycle G
//    and compares the outputs against constants. Inputs change just after
//    the falling edge and outputs are sampled 1 time unit later, well away
//    from the rising edge.
// ---------------------------------------------------------------------------
module tb_chimera_clu_pwr_seq;

   logic       soc_clk_i = 1'b0;
   logic       rst_i     = 1'b1;
   logic [4:0] req_valid_i = '0;
   logic [4:0] req_on_i    = '0;
   logic [4:0] busy_i      = '0;
   logic [4:0] req_ready_o;
   logic [4:0] clu_clk_en_o;
   logic [4:0] clu_rst_no;
   logic [4:0] clu_isolate_o;
   logic [4:0] clu_active_o;
   logic       done_o;
   logic       error_o;
   logic [2:0] done_idx_o;

   int n_checks = 0;
   int n_pass   = 0;

   chimera_clu_pwr_seq #(
      .NumClusters    (5),
      .ClkSettleCycles(4),
      .RstHoldCycles  (8),
      .DrainTimeout   (16)
   ) dut (
      .soc_clk_i    (soc_clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_on_i     (req_on_i),
      .req_ready_o  (req_ready_o),
      .busy_i       (busy_i),
      .clu_clk_en_o (clu_clk_en_o),
      .clu_rst_no   (clu_rst_no),
      .clu_isolate_o(clu_isolate_o),
      .clu_active_o (clu_active_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .done_idx_o   (done_idx_o)
   );

   // 10 time-unit clock period.
   always #5 soc_clk_i = ~soc_clk_i;

   // Absolute watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   // Advance n cycles; lands 1 unit after a falling edge.
   task automatic cyc(input int n);
      repeat (n) @(negedge soc_clk_i);
      #1;
   endtask

   // Holds reset for three edges with requests pending and checks that
   // every output sits at its reset value, then releases reset.
   task automatic test_reset();
      rst_i       = 1'b1;
      req_valid_i = 5'b11111;
      req_on_i    = 5'b11111;
      busy_i      = '0;
      cyc(3);
      n_checks++; if (clu_clk_en_o !== 5'b00000) $display("[TB] FAIL rst_clk_en: got %b expected %b", clu_clk_en_o, 5'b00000); else n_pass++;
      n_checks++; if (clu_rst_no !== 5'b00000) $display("[TB] FAIL rst_rst_n: got %b expected %b", clu_rst_no, 5'b00000); else n_pass++;
      n_checks++; if (clu_isolate_o !== 5'b11111) $display("[TB] FAIL rst_iso: got %b expected %b", clu_isolate_o, 5'b11111); else n_pass++;
      n_checks++; if (clu_active_o !== 5'b00000) $display("[TB] FAIL rst_active: got %b expected %b", clu_active_o, 5'b00000); else n_pass++;
      n_checks++; if (req_ready_o !== 5'b00000) $display("[TB] FAIL rst_ready: got %b expected %b", req_ready_o, 5'b00000); else n_pass++;
      n_checks++; if ({done_o, error_o, done_idx_o} !== 5'b00000) $display("[TB] FAIL rst_done: got %b expected %b", {done_o, error_o, done_idx_o}, 5'b00000); else n_pass++;
      req_valid_i = '0;
      req_on_i    = '0;
      cyc(1);
      rst_i = 1'b0;
   endtask

   // Full power-up of cluster 2 with exact cycle offsets from the grant.
   task automatic test_power_up();
      cyc(1);
      req_valid_i = 5'b00100;
      req_on_i    = 5'b00100;
      #1;
      n_checks++; if (req_ready_o !== 5'b00100) $display("[TB] FAIL pu_grant: got %b expected %b", req_ready_o, 5'b00100); else n_pass++;
      cyc(1); // G+1
      req_valid_i = '0;
      #1;
      n_checks++; if (req_ready_o !== 5'b00000) $display("[TB] FAIL pu_grant_pulse: got %b expected %b", req_ready_o, 5'b00000); else n_pass++;
      n_checks++; if (clu_clk_en_o !== 5'b00100) $display("[TB] FAIL pu_clk_en: got %b expected %b", clu_clk_en_o, 5'b00100); else n_pass++;
      cyc(3); // G+4
      n_checks++; if (clu_rst_no !== 5'b00000) $display("[TB] FAIL pu_rst_early: got %b expected %b", clu_rst_no, 5'b00000); else n_pass++;
      cyc(1); // G+5
      n_checks++; if (clu_rst_no !== 5'b00100) $display("[TB] FAIL pu_rst_rel: got %b expected %b", clu_rst_no, 5'b00100); else n_pass++;
      cyc(7); // G+12
      n_checks++; if ({clu_isolate_o, clu_active_o} !== {5'b11111, 5'b00000}) $display("[TB] FAIL pu_iso_early: got %b expected %b", {clu_isolate_o, clu_active_o}, {5'b11111, 5'b00000}); else n_pass++;
      cyc(1); // G+13, FINISH
      n_checks++; if ({clu_isolate_o, clu_active_o, done_o} !== {5'b11011, 5'b00100, 1'b0}) $display("[TB] FAIL pu_active: got %b expected %b", {clu_isolate_o, clu_active_o, done_o}, {5'b11011, 5'b00100, 1'b0}); else n_pass++;
      cyc(1); // G+14
      n_checks++; if ({done_o, error_o, done_idx_o} !== {1'b1, 1'b0, 3'd2}) $display("[TB] FAIL pu_done: got %b expected %b", {done_o, error_o, done_idx_o}, {1'b1, 1'b0, 3'd2}); else n_pass++;
      cyc(1);
      n_checks++; if (done_o !== 1'b0) $display("[TB] FAIL pu_done_pulse: got %b expected %b", done_o, 1'b0); else n_pass++;
   endtask

   // Power-down of cluster 2 while busy_i[2] is high for cycles G..G+9.
   task automatic test_power_down_busy();
      bit rst_ok;
      cyc(1);
      req_valid_i = 5'b00100;
      req_on_i    = 5'b00000;
      busy_i      = 5'b00100;
      #1;
      n_checks++; if (req_ready_o !== 5'b00100) $display("[TB] FAIL pd_grant: got %b expected %b", req_ready_o, 5'b00100); else n_pass++;
      cyc(1); // G+1, DRAIN
      req_valid_i = '0;
      n_checks++; if (clu_isolate_o !== 5'b11111) $display("[TB] FAIL pd_iso: got %b expected %b", clu_isolate_o, 5'b11111); else n_pass++;
      rst_ok = 1'b1;
      for (int k = 2; k <= 9; k++) begin
         cyc(1);
         if (clu_rst_no !== 5'b00100) rst_ok = 1'b0;
      end
      cyc(1); // G+10
      busy_i = '0;
      if (clu_rst_no !== 5'b00100) rst_ok = 1'b0;
      n_checks++; if (rst_ok !== 1'b1) $display("[TB] FAIL pd_rst_held_while_busy: got %b expected %b", rst_ok, 1'b1); else n_pass++;
      cyc(1); // G+11, RST_ASSERT
      n_checks++; if (clu_rst_no !== 5'b00000) $display("[TB] FAIL pd_rst_assert: got %b expected %b", clu_rst_no, 5'b00000); else n_pass++;
      cyc(7); // G+18
      n_checks++; if (clu_clk_en_o !== 5'b00100) $display("[TB] FAIL pd_clk_early: got %b expected %b", clu_clk_en_o, 5'b00100); else n_pass++;
      cyc(1); // G+19, CLK_OFF
      n_checks++; if ({clu_clk_en_o, clu_active_o} !== 10'b0) $display("[TB] FAIL pd_clk_off: got %b expected %b", {clu_clk_en_o, clu_active_o}, 10'b0); else n_pass++;
      cyc(2); // G+21
      n_checks++; if ({done_o, error_o, done_idx_o} !== {1'b1, 1'b0, 3'd2}) $display("[TB] FAIL pd_done: got %b expected %b", {done_o, error_o, done_idx_o}, {1'b1, 1'b0, 3'd2}); else n_pass++;
      n_checks++; if (clu_isolate_o !== 5'b11111) $display("[TB] FAIL pd_iso_final: got %b expected %b", clu_isolate_o, 5'b11111); else n_pass++;
   endtask

   // Powers cluster 0 up, then tries to power it down with busy_i[0] stuck.
   task automatic test_drain_timeout();
      cyc(1);
      req_valid_i = 5'b00001;
      req_on_i    = 5'b00001;
      cyc(1);
      req_valid_i = '0;
      cyc(13); // G'+14, done of power-up, FSM idle
      n_checks++; if ({done_o, done_idx_o, clu_active_o} !== {1'b1, 3'd0, 5'b00001}) $display("[TB] FAIL dt_powerup: got %b expected %b", {done_o, done_idx_o, clu_active_o}, {1'b1, 3'd0, 5'b00001}); else n_pass++;
      req_valid_i = 5'b00001;
      req_on_i    = 5'b00000;
      busy_i      = 5'b00001;
      #1;
      n_checks++; if (req_ready_o !== 5'b00001) $display("[TB] FAIL dt_grant: got %b expected %b", req_ready_o, 5'b00001); else n_pass++;
      cyc(1); // G+1
      req_valid_i = '0;
      cyc(15); // G+16, last DRAIN cycle
      n_checks++; if ({clu_isolate_o, done_o} !== {5'b11111, 1'b0}) $display("[TB] FAIL dt_draining: got %b expected %b", {clu_isolate_o, done_o}, {5'b11111, 1'b0}); else n_pass++;
      cyc(1); // G+17, FINISH
      n_checks++; if ({clu_isolate_o, clu_active_o} !== {5'b11110, 5'b00001}) $display("[TB] FAIL dt_abort: got %b expected %b", {clu_isolate_o, clu_active_o}, {5'b11110, 5'b00001}); else n_pass++;
      cyc(1); // G+18
      n_checks++; if ({done_o, error_o, done_idx_o} !== {1'b1, 1'b1, 3'd0}) $display("[TB] FAIL dt_error: got %b expected %b", {done_o, error_o, done_idx_o}, {1'b1, 1'b1, 3'd0}); else n_pass++;
      n_checks++; if ({clu_rst_no, clu_clk_en_o, clu_active_o} !== {5'b00001, 5'b00001, 5'b00001}) $display("[TB] FAIL dt_still_up: got %b expected %b", {clu_rst_no, clu_clk_en_o, clu_active_o}, {5'b00001, 5'b00001, 5'b00001}); else n_pass++;
      cyc(1);
      busy_i = '0;
      n_checks++; if ({done_o, error_o} !== 2'b00) $display("[TB] FAIL dt_error_pulse: got %b expected %b", {done_o, error_o}, 2'b00); else n_pass++;
   endtask

   // Two batches of simultaneous no-op requests on clusters 0, 1 and 4,
   // starting from a freshly reset round-robin pointer.
   task automatic test_round_robin();
      for (int b = 0; b < 2; b++) begin
         int         order[3];
         int         n;
         logic [4:0] pend;
         bit         onehot_ok;
         n         = 0;
         pend      = '0;
         onehot_ok = 1'b1;
         order     = '{-1, -1, -1};
         cyc(1);
         req_valid_i = 5'b10011;
         req_on_i    = 5'b00000;
         for (int c = 0; c < 20 && n < 3; c++) begin
            #1;
            pend = req_ready_o;
            if (pend !== 5'b00000) begin
               if (!$onehot(pend)) onehot_ok = 1'b0;
               for (int k = 0; k < 5; k++) if (pend[k]) order[n] = k;
               n++;
            end
            cyc(1);
            req_valid_i = req_valid_i & ~pend;
         end
         req_valid_i = '0;
         n_checks++; if (n !== 3) $display("[TB] FAIL rr_grant_count batch%0d: got %0d expected %0d", b, n, 3); else n_pass++;
         n_checks++; if (onehot_ok !== 1'b1) $display("[TB] FAIL rr_onehot batch%0d: got %b expected %b", b, onehot_ok, 1'b1); else n_pass++;
         n_checks++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 4)
            $display("[TB] FAIL rr_order batch%0d: got %0d,%0d,%0d expected 0,1,4", b, order[0], order[1], order[2]);
         else n_pass++;
         cyc(3);
      end
   endtask

   // Power cluster 3 up, then request power-up again: done_o must appear
   // exactly two cycles after the grant with all outputs unchanged.
   task automatic test_noop();
      cyc(1);
      req_valid_i = 5'b01000;
      req_on_i    = 5'b01000;
      cyc(1);
      req_valid_i = '0;
      cyc(13); // done of the real power-up, FSM idle
      n_checks++; if ({done_o, done_idx_o} !== {1'b1, 3'd3}) $display("[TB] FAIL noop_setup: got %b expected %b", {done_o, done_idx_o}, {1'b1, 3'd3}); else n_pass++;
      req_valid_i = 5'b01000;
      req_on_i    = 5'b01000;
      #1;
      n_checks++; if (req_ready_o !== 5'b01000) $display("[TB] FAIL noop_grant: got %b expected %b", req_ready_o, 5'b01000); else n_pass++;
      cyc(1); // G+1, FINISH
      req_valid_i = '0;
      n_checks++; if (done_o !== 1'b0) $display("[TB] FAIL noop_done_early: got %b expected %b", done_o, 1'b0); else n_pass++;
      cyc(1); // G+2
      n_checks++; if ({done_o, error_o, done_idx_o} !== {1'b1, 1'b0, 3'd3}) $display("[TB] FAIL noop_done: got %b expected %b", {done_o, error_o, done_idx_o}, {1'b1, 1'b0, 3'd3}); else n_pass++;
      n_checks++; if ({clu_clk_en_o, clu_rst_no, clu_isolate_o, clu_active_o} !== {5'b01000, 5'b01000, 5'b10111, 5'b01000})
         $display("[TB] FAIL noop_outputs: got %b expected %b", {clu_clk_en_o, clu_rst_no, clu_isolate_o, clu_active_o}, {5'b01000, 5'b01000, 5'b10111, 5'b01000});
      else n_pass++;
   endtask

   // Reset hits while cluster 1 is in RST_REL; the sequence must be dropped
   // silently and a new request accepted right after release.
   task automatic test_reset_mid();
      bit seen_done;
      bit got_done;
      cyc(1);
      req_valid_i = 5'b00010;
      req_on_i    = 5'b00010;
      cyc(1);
      req_valid_i = '0;
      cyc(5); // G+6, inside RST_REL
      n_checks++; if (clu_rst_no !== 5'b01010) $display("[TB] FAIL rm_in_rst_rel: got %b expected %b", clu_rst_no, 5'b01010); else n_pass++;
      rst_i = 1'b1;
      cyc(1);
      n_checks++; if ({clu_clk_en_o, clu_rst_no, clu_isolate_o, clu_active_o, done_o} !== {5'b00000, 5'b00000, 5'b11111, 5'b00000, 1'b0})
         $display("[TB] FAIL rm_reset_values: got %b expected %b", {clu_clk_en_o, clu_rst_no, clu_isolate_o, clu_active_o, done_o}, {5'b00000, 5'b00000, 5'b11111, 5'b00000, 1'b0});
      else n_pass++;
      seen_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         cyc(1);
         if (done_o !== 1'b0) seen_done = 1'b1;
      end
      rst_i       = 1'b0;
      req_valid_i = 5'b00010;
      req_on_i    = 5'b00010;
      #1;
      n_checks++; if (seen_done !== 1'b0) $display("[TB] FAIL rm_no_done: got %b expected %b", seen_done, 1'b0); else n_pass++;
      n_checks++; if (req_ready_o !== 5'b00010) $display("[TB] FAIL rm_fresh_grant: got %b expected %b", req_ready_o, 5'b00010); else n_pass++;
      cyc(1);
      req_valid_i = '0;
      got_done = 1'b0;
      for (int c = 0; c < 30 && !got_done; c++) begin
         cyc(1);
         if (done_o === 1'b1) got_done = 1'b1;
      end
      n_checks++; if ({got_done, done_idx_o, clu_active_o} !== {1'b1, 3'd1, 5'b00010}) $display("[TB] FAIL rm_fresh_done: got %b expected %b", {got_done, done_idx_o, clu_active_o}, {1'b1, 3'd1, 5'b00010}); else n_pass++;
   endtask

   // Scenario sequence; the second reset puts the round-robin pointer back
   // to zero before the arbitration test.
   initial begin
      $display("[TB] starting chimera_clu_pwr_seq bench");
      test_reset();
      test_power_up();
      test_power_down_busy();
      test_drain_timeout();
      test_reset();
      test_round_robin();
      test_noop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
